// File: rtl/pipelined_mant_adder_if.sv
// rtl/pipelined_mant_adder_if.sv - operation/result handshake bundle for the pipelined mantissa adder
interface pipelined_mant_adder_if #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 9
);
  // Operation side (exponent-align stage -> adder)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [TAG_W-1:0] tag_in;

  // Result side (adder -> normaliser)
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             neg;
  logic [TAG_W-1:0] tag_out;

  // Producer of operations / consumer of results
  modport master (
    output in_valid, a, b, sub, tag_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, neg, tag_out
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, sub, tag_in, out_ready,
    output in_ready, out_valid, sum, carry_out, neg, tag_out
  );
endinterface

// File: rtl/pipelined_mant_adder.sv
// rtl/pipelined_mant_adder.sv - segmented-carry pipelined mantissa add/sub; optional MANT_ADD_ABS_EN magnitude stage
module pipelined_mant_adder #(
  parameter int WIDTH = 24,
  parameter int SEG   = 2,
  parameter int TAG_W = 9
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_mant_adder_if.slave  bus
);

  localparam int CW = WIDTH / SEG;

`ifdef MANT_ADD_ABS_EN
  // The sub bit rides along with the tag so the magnitude stage knows the op.
  localparam int MW = TAG_W + 1;
`else
  localparam int MW = TAG_W;
`endif

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipelined_mant_adder: WIDTH must be a multiple of SEG");
  end

  logic             live_q;
  logic             advance;
  logic             take;
  logic [WIDTH-1:0] b_eff;
  logic [MW-1:0]    meta_in;

  // in_ready is held low until the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // Global stall: every stage moves together or none does
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = live_q && advance;
  assign take         = bus.in_valid && live_q;

  // Subtraction is A + ~B + 1; the +1 enters as stage-1 carry-in
  assign b_eff = bus.sub ? ~bus.b : bus.b;

`ifdef MANT_ADD_ABS_EN
  assign meta_in = {bus.sub, bus.tag_in};
`else
  assign meta_in = bus.tag_in;
`endif

  for (genvar s = 0; s < SEG; s++) begin : g_stage
    localparam int DONE = (s + 1) * CW;  // result bits resolved once this stage has captured

    logic            vin;
    logic            cin;
    logic [MW-1:0]   m_in;
    logic [CW-1:0]   ca;
    logic [CW-1:0]   cb;
    logic [CW:0]     csum;
    logic [DONE-1:0] res_d;

    logic            v_q;
    logic            c_q;
    logic [MW-1:0]   meta_q;
    logic [DONE-1:0] res_q;

    if (s == 0) begin : g_src
      assign vin   = take;
      assign cin   = bus.sub;
      assign m_in  = meta_in;
      assign ca    = bus.a[CW-1:0];
      assign cb    = b_eff[CW-1:0];
      assign res_d = csum[CW-1:0];
    end else begin : g_src
      assign vin   = g_stage[s-1].v_q;
      assign cin   = g_stage[s-1].c_q;
      assign m_in  = g_stage[s-1].meta_q;
      assign ca    = g_stage[s-1].g_rem.ra_q[CW-1:0];
      assign cb    = g_stage[s-1].g_rem.rb_q[CW-1:0];
      assign res_d = {csum[CW-1:0], g_stage[s-1].res_q};
    end

    // One CW-bit chunk per stage; the chunk carry is registered for the next stage
    assign csum = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, cin};

    // Operand chunks still to be consumed travel with the op (not needed after the last stage)
    if (s < SEG - 1) begin : g_rem
      localparam int REM = WIDTH - DONE;

      logic [REM-1:0] ra_d;
      logic [REM-1:0] rb_d;
      logic [REM-1:0] ra_q;
      logic [REM-1:0] rb_q;

      if (s == 0) begin : g_rsrc
        assign ra_d = bus.a[WIDTH-1:CW];
        assign rb_d = b_eff[WIDTH-1:CW];
      end else begin : g_rsrc
        assign ra_d = g_stage[s-1].g_rem.ra_q[REM+CW-1:CW];
        assign rb_d = g_stage[s-1].g_rem.rb_q[REM+CW-1:CW];
      end

      // Hold remaining operand chunks; load only for a valid op so bubbles leave them alone
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (advance && vin) begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end

    // Stage register: valid follows the pipe on advance, data loads only for valid ops
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        c_q    <= 1'b0;
        meta_q <= '0;
        res_q  <= '0;
      end else if (advance) begin
        v_q <= vin;
        if (vin) begin
          c_q    <= csum[CW];
          meta_q <= m_in;
          res_q  <= res_d;
        end
      end
    end
  end

  logic             last_valid;
  logic             last_carry;
  logic [MW-1:0]    last_meta;
  logic [WIDTH-1:0] last_res;

  assign last_valid = g_stage[SEG-1].v_q;
  assign last_carry = g_stage[SEG-1].c_q;
  assign last_meta  = g_stage[SEG-1].meta_q;
  assign last_res   = g_stage[SEG-1].res_q;

`ifdef MANT_ADD_ABS_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             raw_neg;
  logic             o_valid;
  logic             o_carry;
  logic             o_neg;
  logic [WIDTH-1:0] o_sum;
  logic [TAG_W-1:0] o_tag;

  // A subtract that borrowed produced a negative two's-complement result
  assign raw_neg = last_meta[TAG_W] && !last_carry;

  // Magnitude stage: negate borrowed differences, pass everything else through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_carry <= 1'b0;
      o_neg   <= 1'b0;
      o_sum   <= '0;
      o_tag   <= '0;
    end else if (advance) begin
      o_valid <= last_valid;
      if (last_valid) begin
        o_carry <= last_carry;
        o_neg   <= raw_neg;
        o_sum   <= raw_neg ? (~last_res + ONE) : last_res;
        o_tag   <= last_meta[TAG_W-1:0];
      end
    end
  end

  assign bus.out_valid = o_valid;
  assign bus.sum       = o_sum;
  assign bus.carry_out = o_carry;
  assign bus.neg       = o_neg;
  assign bus.tag_out   = o_tag;
`else
  assign bus.out_valid = last_valid;
  assign bus.sum       = last_res;
  assign bus.carry_out = last_carry;
  assign bus.neg       = 1'b0;
  assign bus.tag_out   = last_meta;
`endif

endmodule

// File: tb/tb_pipelined_mant_adder.sv
// tb/tb_pipelined_mant_adder.sv - directed table-driven bench for pipelined_mant_adder
module tb_pipelined_mant_adder;

  localparam int WIDTH = 24;
  localparam int SEG   = 2;
  localparam int TAG_W = 9;
`ifdef MANT_ADD_ABS_EN
  localparam int LAT = SEG + 1;
  localparam bit ABS = 1'b1;
`else
  localparam int LAT = SEG;
  localparam bit ABS = 1'b0;
`endif

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        sub;
    logic [8:0]  tag;
    logic [23:0] sum;
    logic        c;
    logic        neg;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipelined_mant_adder_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  pipelined_mant_adder #(.WIDTH(WIDTH), .SEG(SEG), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic run_one(input vec_t v, input string nm);
    int w;
    int lat;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.sub      = v.sub;
    bus.tag_in   = v.tag;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    w = 0;
    while (!bus.in_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(LAT));
    chk({nm, "_sum"},     32'(bus.sum), 32'(v.sum));
    chk({nm, "_carry"},   32'(bus.carry_out), 32'(v.c));
    chk({nm, "_neg"},     32'(bus.neg), 32'(v.neg));
    chk({nm, "_tag"},     32'(bus.tag_out), 32'(v.tag));
    @(posedge clk); #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] bp_a[5];
    logic [23:0] bp_b[5];
    int          sent;
    int          got;
    int          stale;
    bit          saw_low;
    bit          held_prev;
    bit          fire_in;
    bit          fire_out;
    logic [23:0] prev_sum;
    logic [8:0]  prev_tag;
    logic        exp_v;

    vt[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 9'h001, 24'h000000, 1'b1, 1'b0};
    vt[1] = '{24'h000FFF, 24'h000001, 1'b0, 9'h002, 24'h001000, 1'b0, 1'b0};
    vt[2] = '{24'h800000, 24'h000001, 1'b1, 9'h003, 24'h7FFFFF, 1'b1, 1'b0};
    vt[3] = '{24'h000001, 24'h000002, 1'b1, 9'h004, ABS ? 24'h000001 : 24'hFFFFFF, 1'b0, ABS};
    vt[4] = '{24'h123456, 24'h654321, 1'b0, 9'h005, 24'h777777, 1'b0, 1'b0};
    vt[5] = '{24'h000000, 24'h000000, 1'b1, 9'h006, 24'h000000, 1'b1, 1'b0};
    vt[6] = '{24'h100000, 24'h0FFFFF, 1'b1, 9'h007, 24'h000001, 1'b1, 1'b0};
    vt[7] = '{24'h000000, 24'h000001, 1'b1, 9'h008, ABS ? 24'h000001 : 24'hFFFFFF, 1'b0, ABS};
    vt[8] = '{24'hFFFFFF, 24'hFFFFFF, 1'b0, 9'h1FF, 24'hFFFFFE, 1'b1, 1'b0};
    vt[9] = '{24'h000800, 24'h000800, 1'b0, 9'h0AA, 24'h001000, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.sum), 32'd0);
    chk("rst_carry",     32'(bus.carry_out), 32'd0);
    chk("rst_neg",       32'(bus.neg), 32'd0);
    chk("rst_tag",       32'(bus.tag_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 10; i++) run_one(vt[i], $sformatf("vec%0d", i));

    // Backpressure: 5 back-to-back ops, out_ready low for 4 cycles
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 24'h0FFF00 + 24'(i + 1);
      bp_b[i] = 24'h000100 * 24'(i + 1);
    end
    sent = 0; got = 0; saw_low = 1'b0; held_prev = 1'b0;
    prev_sum = '0; prev_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus.out_ready = (cyc >= 4);
      if (sent < 5) begin
        bus.in_valid = 1'b1;
        bus.a        = bp_a[sent];
        bus.b        = bp_b[sent];
        bus.sub      = 1'b0;
        bus.tag_in   = 9'(sent + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (!bus.in_ready) saw_low = 1'b1;
      if (held_prev) begin
        chk("bp_hold_sum", 32'(bus.sum), 32'(prev_sum));
        chk("bp_hold_tag", 32'(bus.tag_out), 32'(prev_tag));
      end
      if (got > 0 && got < 5 && bus.out_ready) chk("bp_no_gap", 32'(bus.out_valid), 32'd1);
      if (fire_out) begin
        chk("bp_order_tag", 32'(bus.tag_out), 32'(got + 1));
        chk("bp_sum",       32'(bus.sum), 32'(bp_a[got] + bp_b[got]));
        got++;
      end
      held_prev = bus.out_valid && !bus.out_ready;
      prev_sum  = bus.sum;
      prev_tag  = bus.tag_out;
      @(posedge clk); #1;
      if (fire_in) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_results", 32'(got), 32'd5);
    chk("bp_in_ready_dropped", 32'(saw_low), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // Bubbles: in_valid 1,0,1,0 -> out_valid same pattern LAT cycles later
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (c < 4) && (c % 2 == 0);
      bus.a        = 24'h000100 + 24'(c);
      bus.b        = 24'h000010;
      bus.sub      = 1'b0;
      bus.tag_in   = 9'(c);
      #1;
      exp_v = (c >= LAT) && (c - LAT < 4) && ((c - LAT) % 2 == 0);
      chk($sformatf("bubble_c%0d", c), 32'(bus.out_valid), 32'(exp_v));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;

    // Reset with two ops in flight
    bus.out_ready = 1'b1;
    bus.a = vt[4].a; bus.b = vt[4].b; bus.sub = vt[4].sub; bus.tag_in = vt[4].tag;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.a = vt[1].a; bus.b = vt[1].b; bus.sub = vt[1].sub; bus.tag_in = vt[1].tag;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    chk("midrst_stale", 32'(stale), 32'd0);
    run_one(vt[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_mant_adder.md
Name: pipelined_mant_adder

Overview:
- Parametrised, pipelined add/subtract unit for floating-point mantissa datapaths.
- Successor to the team's fixed 24-bit combinational mantissa adder: configurable width, segmented carry pipeline, per-operation add/sub mode, valid/ready handshake and sideband tag pass-through.
- Sits between the exponent-align stage and the normaliser. The tag field carries the exponent and sign through the adder alongside the result.

Parameters:
- WIDTH, 24: operand and sum width in bits.
- SEG, 2: number of carry-pipeline segments, which equals the base latency. WIDTH % SEG must be 0. Each segment is CW = WIDTH/SEG bits wide.
- TAG_W, 9: sideband tag width, passed through unchanged.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an input this cycle.
- a  in  WIDTH  operand A (unsigned).
- b  in  WIDTH  operand B (unsigned).
- sub  in  1  0 = A+B; 1 = A-B.
- tag_in  in  TAG_W  sideband data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- carry_out  out  1  add: carry out of the MSB. Sub: 1 = no borrow (A>=B).
- neg  out  1  result negated; only driven when MANT_ADD_ABS_EN is defined, otherwise tied to 0.
- tag_out  out  TAG_W  tag aligned with sum.

Behaviour:
- Reset:
  - All stage valid bits are cleared immediately and asynchronously.
  - out_valid=0, sum=0, carry_out=0, neg=0, tag_out=0.
  - in_ready=1 from the first clock edge after reset is released.
- Operation: sub=1 computes A + ~B + 1. The inversion and carry-in are applied at stage-1 capture.
- Pipeline: SEG register stages.
  - Stage k (1..SEG) adds chunk k-1 (bits [k*CW-1:(k-1)*CW]) of the operands plus the carry registered from stage k-1. Stage 1 uses the sub bit as its carry-in.
  - Chunk results that are already computed are carried forward in the stage registers. Operand chunks not yet consumed are also carried forward.
  - The final stage's carry becomes carry_out.
- Latency: SEG cycles from the input handshake to out_valid, when out_ready stays high.
- Throughput: one operation per cycle.
- Flow control: global stall.
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational).
  - When advance=0, every stage register holds its value.
  - A bubble (in_valid=0 while advance=1) propagates as an invalid stage.
- Output hold: sum, carry_out, neg and tag_out are stable while out_valid=1 and out_ready=0. The output changes only after a handshake.
- Simultaneous input handshake and output handshake in the same cycle are both accepted; no bubble is inserted.
- Ordering: results leave in strict input order. No operation is lost or duplicated under any out_ready pattern.
- Width rules:
  - Add: {carry_out,sum} = A+B exactly, WIDTH+1 bits.
  - Sub: sum = (A-B) mod 2^WIDTH.
- Boundary cases:
  - SEG=1 degenerates to a single registered full-width adder.
  - A carry rippling across every segment boundary (for example all-ones + 1) must resolve correctly.
- Reset mid-operation: all in-flight operations are discarded. No output appears for them after reset is released.

Optional Feature:
- MANT_ADD_ABS_EN defined:
  - Adds one extra output stage, so latency becomes SEG+1.
  - For sub=1 with carry_out=0, the stage outputs sum = (~raw)+1 (the magnitude of A-B) and sets neg=1.
  - Otherwise it passes raw through with neg=0.
  - carry_out keeps its raw value.
  - The extra stage takes part in the same global stall.
- Not defined: no extra stage, latency SEG, neg tied to 0.

Test Plan:
- WIDTH=24, SEG=2, out_ready=1: a=0xFFFFFF, b=0x000001, sub=0 -> sum=0x000000, carry_out=1, out_valid exactly 2 cycles after the handshake.
- Segment-boundary carry: a=0x000FFF, b=0x000001, sub=0 -> sum=0x001000, carry_out=0.
- Subtract:
  - a=0x800000, b=0x000001, sub=1 -> sum=0x7FFFFF, carry_out=1.
  - a=0x000001, b=0x000002, sub=1 -> sum=0xFFFFFF, carry_out=0.
  - Same case with MANT_ADD_ABS_EN: sum=0x000001, neg=1, latency 3.
- Backpressure: 5 back-to-back operations (tags 1..5) with out_ready held low for 4 cycles, then high -> in_ready drops while the pipeline is full, outputs stay stable, all 5 results arrive in tag order with no gaps once out_ready=1.
- Bubbles: in_valid toggling 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0, delayed by SEG cycles.
- Reset: assert rst_n=0 with 2 operations in flight -> out_valid=0 immediately. After release, no stale results appear, and the first new operation has correct latency.
